hex_string_serializer: RTL

- Converts a DATA_WIDTH-bit binary word into a stream of ASCII hex characters, one character per handshake, for the LCD controller's character path.
- Generalises the fixed 4-bit nibble-to-ASCII mapping:
  - parametrised word width;
  - optional "0x" prefix;
  - run-time lowercase and leading-zero-suppression modes;
  - valid/ready backpressure on both sides.
- Sits between the CPU debug/register tap and the LCD write sequencer.

---
 rtl/hex_string_serializer_pkg.sv | 17 +
 rtl/hex_nibble_to_ascii.sv | 20 ++
 rtl/hex_string_serializer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hex_string_serializer_pkg.sv
// rtl/hex_string_serializer_pkg.sv - shared ASCII constants and FSM encoding for the hex serializer
package hex_string_serializer_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] ASCII_NUL     = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PFX0   = 2'd1,
    ST_PFX1   = 2'd2,
    ST_DIGITS = 2'd3
  } state_t;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// rtl/hex_nibble_to_ascii.sv - one nibble to its ASCII hex digit, run-time selectable case
module hex_nibble_to_ascii
  import hex_string_serializer_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lower,
  output logic [7:0] ascii
);

  // 0-9 offset from '0'; 10-15 offset from 'a' or 'A'
  always_comb begin
    ascii = ASCII_ZERO;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = (lower ? ASCII_LOWER_A : ASCII_UPPER_A) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_string_serializer.sv
// rtl/hex_string_serializer.sv - binary word to ASCII hex character stream with valid/ready on both sides
module hex_string_serializer
  import hex_string_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PREFIX_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_lower,
  input  logic                  in_suppress,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [7:0]            char_data,
  output logic                  char_last,
  output logic                  busy
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] word;
  logic                  lower_q;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [IDX_W-1:0]      msnz_idx, start_idx;
  logic                  accept, advance;
  logic [3:0]            cur_nibble;
  logic [7:0]            digit_char;

  assign accept  = in_valid && (state == ST_IDLE);
  assign advance = char_valid && char_ready;

  // Priority encoder: highest non-zero nibble of the offered word (0 for an all-zero word).
  // Suppression only shapes the starting index, so it is not kept past the accept.
  always_comb begin
    msnz_idx = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (in_data[4*i +: 4] != 4'h0) begin
        msnz_idx = IDX_W'(i);
      end
    end
  end

  assign start_idx = in_suppress ? msnz_idx : IDX_W'(NIBBLES - 1);

  // Next-state and nibble index: prefix states then digits, MSB nibble first
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (PREFIX_EN != 0) ? ST_PFX0 : ST_DIGITS;
          idx_next   = start_idx;
        end
      end
      ST_PFX0: begin
        if (advance) state_next = ST_PFX1;
      end
      ST_PFX1: begin
        if (advance) state_next = ST_DIGITS;
      end
      ST_DIGITS: begin
        if (advance) begin
          if (idx == '0) begin
            state_next = ST_IDLE;
          end else begin
            idx_next = idx - 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, index and input latches; reset discards any partial string
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      word    <= '0;
      lower_q <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (accept) begin
        word    <= in_data;
        lower_q <= in_lower;
      end
    end
  end

  assign cur_nibble = word[{idx, 2'b00} +: 4];

  hex_nibble_to_ascii u_nibble_to_ascii (
    .nibble (cur_nibble),
    .lower  (lower_q),
    .ascii  (digit_char)
  );

  // Outputs decode registered state only, so they stay stable under backpressure
  always_comb begin
    char_data = ASCII_NUL;
    case (state)
      ST_PFX0:   char_data = ASCII_ZERO;
      ST_PFX1:   char_data = ASCII_X;
      ST_DIGITS: char_data = digit_char;
      default:   char_data = ASCII_NUL;
    endcase
  end

  assign char_valid = (state != ST_IDLE);
  assign char_last  = (state == ST_DIGITS) && (idx == '0);
  assign in_ready   = (state == ST_IDLE);
  assign busy       = !in_ready;

endmodule
